// File: rtl/iram_if.sv
// iram_if: signal bundle between iram_ctrl, the fetch unit and the backing instruction memory.
interface iram_if #(
    parameter int PC_SIZE    = 32,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4
);
    localparam int IW = $clog2(LINE_WORDS);
    logic               i_miss;
    logic [PC_SIZE-1:0] ram_address;
    logic [WORD_W-1:0]  mem_word;
    logic               word_ready;
    logic [IW-1:0]      word_idx;
    logic               busy;
    logic               ext_req;
    logic [PC_SIZE-1:0] ext_addr;
    logic               ext_ack;
    logic               ext_rvalid;
    logic [WORD_W-1:0]  ext_rdata;
    logic [15:0]        miss_count;
    modport master (
        output i_miss, ram_address, ext_ack, ext_rvalid, ext_rdata,
        input  mem_word, word_ready, word_idx, busy, ext_req, ext_addr, miss_count
    );
    modport slave (
        input  i_miss, ram_address, ext_ack, ext_rvalid, ext_rdata,
        output mem_word, word_ready, word_idx, busy, ext_req, ext_addr, miss_count
    );
endinterface

// File: rtl/iram_ctrl.sv
// iram_ctrl: turns an instruction-cache miss into one line burst and streams the
// returned words to the fetch unit, one registered pulse per word.
module iram_ctrl #(
    parameter int PC_SIZE    = 32,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input logic   clk,
    input logic   nrst,
    iram_if.slave bus
);
    localparam int IW = $clog2(LINE_WORDS);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, BURST = 2'd2, DONE = 2'd3;
    logic [1:0]         state, next;
    logic [IW-1:0]      beat, word_idx;
    logic [PC_SIZE-1:0] ext_addr;
    logic [WORD_W-1:0]  mem_word;
    logic               word_ready;
    logic [15:0]        miss_cnt;
    logic               take, last, start;
    assign start = state == IDLE && bus.i_miss;
    assign take  = state == BURST && bus.ext_rvalid;
    assign last  = beat == IW'(LINE_WORDS - 1);
    // DONE holds until the miss level drops so a stale miss cannot re-trigger
    assign next = state == IDLE  ? (bus.i_miss ? REQ : IDLE)
                : state == REQ   ? (bus.ext_ack ? BURST : REQ)
                : state == BURST ? (take && last ? DONE : BURST)
                :                  (bus.i_miss ? DONE : IDLE);
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            state      <= IDLE;
            beat       <= '0;
            word_idx   <= '0;
            ext_addr   <= '0;
            mem_word   <= '0;
            word_ready <= 1'b0;
            miss_cnt   <= '0;
        end else begin
            state      <= next;
            word_ready <= take;
            if (take) begin
                mem_word <= bus.ext_rdata;
                word_idx <= beat;
                beat     <= beat + IW'(1);
            end
            if (start) begin
                ext_addr <= bus.ram_address & ~PC_SIZE'(LINE_WORDS * 4 - 1);
                beat     <= '0;
                miss_cnt <= miss_cnt + {15'd0, miss_cnt != 16'hFFFF};
            end
        end
    assign bus.mem_word   = mem_word;
    assign bus.word_ready = word_ready;
    assign bus.word_idx   = word_idx;
    assign bus.busy       = state != IDLE;
    assign bus.ext_req    = state == REQ;
    assign bus.ext_addr   = ext_addr;
    assign bus.miss_count = miss_cnt;
endmodule

// File: tb/tb_iram_ctrl.sv
// tb_iram_ctrl: randomized scenario bench for iram_ctrl against a transaction-level model
// (expected line base, word list with delivery cycles, saturating miss count).
module tb_iram_ctrl;
    localparam int PC = 32, W = 32, LW = 4;
    logic clk = 1'b0, nrst = 1'b0;
    always #5 clk = ~clk;
    iram_if #(.PC_SIZE(PC), .WORD_W(W), .LINE_WORDS(LW)) bus();
    iram_ctrl #(.PC_SIZE(PC), .WORD_W(W), .LINE_WORDS(LW)) dut (.clk(clk), .nrst(nrst), .bus(bus));
    int n_cmp = 0, n_err = 0;
    int cyc = 0, req_cyc = 0;
    int exp_cnt = 0;
    logic [31:0] exp_last = '0;
    int got_idx[$], got_cyc[$];
    logic [31:0] got_word[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.word_ready === 1'b1) begin
            got_idx.push_back(int'(bus.word_idx));
            got_word.push_back(bus.mem_word);
            got_cyc.push_back(cyc);
        end
        if (bus.ext_req === 1'b1) req_cyc <= req_cyc + 1;
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_miss(input logic [31:0] addr, input int ack_d, input int mode, input int base_w,
                           input int stale, input bit drop_mid, input bit chk_cnt);
        logic [31:0] w[LW];
        logic [31:0] ea;
        int exp_c[$];
        int s_w, s_r, p, n;
        bit v;
        for (int i = 0; i < LW; i++) w[i] = base_w >= 0 ? 32'(base_w + i) : $urandom;
        ea = addr & ~32'(LW * 4 - 1);
        exp_cnt = exp_cnt < 65535 ? exp_cnt + 1 : 65535;
        s_w = got_idx.size();
        s_r = req_cyc;
        bus.i_miss = 1'b1;
        bus.ram_address = addr;
        tick();
        n_cmp++;
        if (bus.ext_req !== 1'b1 || bus.busy !== 1'b1 || bus.ext_addr !== ea) begin
            n_err++;
            $display("FAIL req_start got req=%b busy=%b addr=%h want req=1 busy=1 addr=%h", bus.ext_req, bus.busy, bus.ext_addr, ea);
        end
        bus.ram_address = $urandom;
        repeat (ack_d - 1) tick();
        bus.ext_ack = 1'b1;
        tick();
        bus.ext_ack = 1'b0;
        n_cmp++;
        if (req_cyc - s_r !== ack_d || bus.ext_req !== 1'b0) begin
            n_err++;
            $display("FAIL req_len got %0d cycles (req now %b) want %0d cycles (req now 0)", req_cyc - s_r, bus.ext_req, ack_d);
        end
        if (drop_mid) bus.i_miss = 1'b0;
        p = 0;
        for (int b = 0; b < LW; ) begin
            v = mode == 0 ? 1'b1 : mode == 1 ? ($urandom_range(0, 2) != 0) : mode[p % 16];
            p++;
            bus.ext_ack = 1'($urandom_range(0, 1));
            bus.ext_rvalid = v;
            bus.ext_rdata = v ? w[b] : $urandom;
            if (v) begin
                exp_c.push_back(cyc + 1);
                b++;
            end
            tick();
        end
        bus.ext_ack = 1'b0;
        bus.ext_rvalid = 1'b1;
        bus.ext_rdata = $urandom;
        if (!drop_mid)
            repeat (stale) begin
                tick();
                bus.ext_rvalid = 1'b0;
                @(negedge clk);
                n_cmp++;
                if (bus.ext_req !== 1'b0 || bus.busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL stale_hold got req=%b busy=%b want req=0 busy=1", bus.ext_req, bus.busy);
                end
            end
        bus.i_miss = 1'b0;
        tick();
        bus.ext_rvalid = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.ext_req !== 1'b0) begin
            n_err++;
            $display("FAIL back_to_idle got busy=%b req=%b want busy=0 req=0", bus.busy, bus.ext_req);
        end
        n = got_idx.size() - s_w;
        n_cmp++;
        if (n !== LW) begin
            n_err++;
            $display("FAIL word_count got %0d want %0d", n, LW);
        end
        for (int i = 0; i < LW && i < n; i++) begin
            n_cmp++;
            if (got_idx[s_w + i] !== i || got_word[s_w + i] !== w[i] || got_cyc[s_w + i] !== exp_c[i]) begin
                n_err++;
                $display("FAIL word%0d got idx=%0d data=%h cyc=%0d want idx=%0d data=%h cyc=%0d", i,
                         got_idx[s_w + i], got_word[s_w + i], got_cyc[s_w + i], i, w[i], exp_c[i]);
            end
        end
        exp_last = w[LW - 1];
        if (chk_cnt) begin
            n_cmp++;
            if (bus.miss_count !== 16'(exp_cnt)) begin
                n_err++;
                $display("FAIL miss_count got %h want %h", bus.miss_count, 16'(exp_cnt));
            end
        end
    endtask
    task automatic test_reset();
        bus.i_miss = 1'b0;
        bus.ram_address = '0;
        bus.ext_ack = 1'b0;
        bus.ext_rvalid = 1'b0;
        bus.ext_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.ext_req, bus.busy, bus.word_ready} !== 3'b000 || bus.ext_addr !== '0 || bus.mem_word !== '0
            || bus.word_idx !== '0 || bus.miss_count !== '0) begin
            n_err++;
            $display("FAIL reset_state got req=%b busy=%b rdy=%b addr=%h word=%h idx=%0d cnt=%h want all 0",
                     bus.ext_req, bus.busy, bus.word_ready, bus.ext_addr, bus.mem_word, bus.word_idx, bus.miss_count);
        end
        tick();
        nrst = 1'b1;
        tick();
    endtask
    task automatic test_basic();
        do_miss(32'h0000_0104, 1, 0, 32'hA0, 1, 1'b0, 1'b1);
    endtask
    task automatic test_delayed_gapped();
        do_miss($urandom, 5, 32'h59, -1, 1, 1'b0, 1'b1);
    endtask
    task automatic test_stale();
        do_miss($urandom, 2, 1, -1, 10, 1'b0, 1'b1);
        do_miss(32'h0000_0200, 1, 0, -1, 1, 1'b0, 1'b1);
    endtask
    task automatic test_spurious();
        int s_w;
        s_w = got_idx.size();
        repeat (3) begin
            bus.ext_rvalid = 1'b1;
            bus.ext_ack = 1'b1;
            bus.ext_rdata = $urandom;
            tick();
            @(negedge clk);
            n_cmp++;
            if (bus.word_ready !== 1'b0 || bus.busy !== 1'b0 || bus.ext_req !== 1'b0) begin
                n_err++;
                $display("FAIL idle_beat got rdy=%b busy=%b req=%b want 0 0 0", bus.word_ready, bus.busy, bus.ext_req);
            end
        end
        bus.ext_rvalid = 1'b0;
        bus.ext_ack = 1'b0;
        tick();
        n_cmp++;
        if (bus.mem_word !== exp_last || bus.word_idx !== 2'(LW - 1) || bus.miss_count !== 16'(exp_cnt)
            || got_idx.size() !== s_w) begin
            n_err++;
            $display("FAIL idle_hold got word=%h idx=%0d cnt=%h new=%0d want word=%h idx=%0d cnt=%h new=0",
                     bus.mem_word, bus.word_idx, bus.miss_count, got_idx.size() - s_w, exp_last, LW - 1, 16'(exp_cnt));
        end
    endtask
    task automatic test_drop();
        do_miss($urandom, 3, 1, -1, 0, 1'b1, 1'b1);
    endtask
    task automatic test_random();
        for (int i = 0; i < 8; i++)
            do_miss($urandom, $urandom_range(1, 6), 1, -1, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1);
    endtask
    task automatic test_reset_mid();
        int s_w;
        bus.i_miss = 1'b1;
        bus.ram_address = $urandom;
        tick();
        bus.ext_ack = 1'b1;
        tick();
        bus.ext_ack = 1'b0;
        bus.ext_rvalid = 1'b1;
        bus.ext_rdata = $urandom;
        tick();
        bus.ext_rdata = $urandom;
        tick();
        nrst = 1'b0;
        #1;
        s_w = got_idx.size();
        exp_cnt = 0;
        n_cmp++;
        if ({bus.ext_req, bus.busy, bus.word_ready} !== 3'b000 || bus.ext_addr !== '0 || bus.mem_word !== '0
            || bus.word_idx !== '0 || bus.miss_count !== '0) begin
            n_err++;
            $display("FAIL async_reset got req=%b busy=%b rdy=%b addr=%h word=%h idx=%0d cnt=%h want all 0",
                     bus.ext_req, bus.busy, bus.word_ready, bus.ext_addr, bus.mem_word, bus.word_idx, bus.miss_count);
        end
        bus.i_miss = 1'b0;
        tick();
        nrst = 1'b1;
        repeat (2) begin
            bus.ext_rdata = $urandom;
            tick();
            @(negedge clk);
            n_cmp++;
            if (bus.word_ready !== 1'b0 || bus.busy !== 1'b0) begin
                n_err++;
                $display("FAIL post_reset_beat got rdy=%b busy=%b want 0 0", bus.word_ready, bus.busy);
            end
        end
        bus.ext_rvalid = 1'b0;
        tick();
        n_cmp++;
        if (got_idx.size() !== s_w) begin
            n_err++;
            $display("FAIL post_reset_words got %0d want 0", got_idx.size() - s_w);
        end
        do_miss($urandom, 2, 1, -1, 1, 1'b0, 1'b1);
    endtask
    task automatic test_saturation();
        force dut.miss_cnt = 16'hFFFE;
        fork
            begin
                @(posedge clk);
                #2;
                release dut.miss_cnt;
            end
        join_none
        do_miss($urandom, 1, 1, -1, 1, 1'b0, 1'b0);
        exp_cnt = 65535;
        do_miss($urandom, 1, 0, -1, 1, 1'b0, 1'b1);
        do_miss($urandom, 2, 1, -1, 0, 1'b0, 1'b1);
    endtask
    initial begin
        test_reset();
        test_basic();
        test_delayed_gapped();
        test_stale();
        test_spurious();
        test_drop();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
